// File: rtl/sram_byte_seq_if.sv
// picorv32-style native memory bus between a CPU (master) and sram_byte_seq (slave).
interface sram_byte_seq_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/sram_byte_seq.sv
// Sequences a 32-bit picorv32 access into four byte accesses on an 8-bit synchronous SRAM.
// Optional macro SRAM_BYTE_SEQ_WSKIP_EN: writes visit only the strobed lanes.
module sram_byte_seq #(
  parameter int unsigned SRAM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  sram_byte_seq_if.slave     bus,
  output logic               sram_csb,
  output logic               sram_web,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [7:0]         sram_din,
  input  logic [7:0]         sram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t               r_state, w_next_state;
  logic [1:0]           r_lane, w_lane_d;
  logic [SRAM_AW-3:0]   r_word;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic                 r_is_read;
  logic                 r_oor;
  logic [31:0]          r_rdata;
  logic                 r_csb, r_web;
  logic [SRAM_AW-1:0]   r_addr;
  logic [7:0]           r_din;

  logic                 w_csb_d, w_web_d;
  logic [SRAM_AW-1:0]   w_addr_d;
  logic [7:0]           w_din_d;
  logic                 w_accept, w_accept_oor;
  logic                 w_in_range, w_req_read;
  logic [1:0]           w_first_lane, w_next_lane, w_prev_lane;
  logic                 w_has_next;
  logic                 w_unused;

  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  assign w_in_range  = (bus.mem_addr[31:SRAM_AW] == '0);
  assign w_req_read  = (bus.mem_wstrb == 4'b0000);
  assign w_prev_lane = r_lane - 2'd1;
  assign w_unused    = &{1'b0, bus.mem_instr, bus.mem_addr[1:0]};

`ifdef SRAM_BYTE_SEQ_WSKIP_EN
  logic [3:0] w_pending;
  // Lanes strictly above the current one that still carry a strobe.
  assign w_pending    = r_wstrb & (4'b1110 << r_lane);
  assign w_first_lane = w_req_read ? 2'd0 : lowest_lane(bus.mem_wstrb);
  assign w_has_next   = r_is_read ? (r_lane != 2'd3) : (|w_pending);
  assign w_next_lane  = r_is_read ? (r_lane + 2'd1) : lowest_lane(w_pending);
`else
  assign w_first_lane = 2'd0;
  assign w_has_next   = (r_lane != 2'd3);
  assign w_next_lane  = r_lane + 2'd1;
`endif

  always_comb begin
    w_next_state = r_state;
    w_lane_d     = r_lane;
    w_csb_d      = 1'b1;
    w_web_d      = 1'b1;
    w_addr_d     = r_addr;
    w_din_d      = r_din;
    w_accept     = 1'b0;
    w_accept_oor = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_valid) begin
          if (w_in_range) begin
            // SRAM outputs are registered, so lane 0 is set up from the live request.
            w_accept     = 1'b1;
            w_next_state = ACCESS;
            w_lane_d     = w_first_lane;
            w_csb_d      = ~(w_req_read | bus.mem_wstrb[w_first_lane]);
            w_web_d      = w_req_read;
            w_addr_d     = {bus.mem_addr[SRAM_AW-1:2], w_first_lane};
            w_din_d      = bus.mem_wdata[{w_first_lane, 3'b000} +: 8];
          end else begin
            // Out-of-range requests pass through DRAIN for a fixed two-cycle response.
            w_accept_oor = 1'b1;
            w_next_state = DRAIN;
          end
        end
      end
      ACCESS: begin
        if (w_has_next) begin
          w_lane_d = w_next_lane;
          w_csb_d  = ~(r_is_read | r_wstrb[w_next_lane]);
          w_web_d  = r_is_read;
          w_addr_d = {r_word, w_next_lane};
          w_din_d  = r_wdata[{w_next_lane, 3'b000} +: 8];
        end else if (r_is_read) begin
          w_next_state = DRAIN;
        end else begin
`ifdef SRAM_BYTE_SEQ_WSKIP_EN
          w_next_state = DRAIN;
`else
          w_next_state = RESP;
`endif
        end
      end
      DRAIN:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lane    <= '0;
      r_word    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_is_read <= 1'b0;
      r_oor     <= 1'b0;
      r_rdata   <= '0;
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_addr    <= '0;
      r_din     <= '0;
    end else begin
      r_state <= w_next_state;
      r_lane  <= w_lane_d;
      r_csb   <= w_csb_d;
      r_web   <= w_web_d;
      r_addr  <= w_addr_d;
      r_din   <= w_din_d;
      if (w_accept) begin
        r_word    <= bus.mem_addr[SRAM_AW-1:2];
        r_wdata   <= bus.mem_wdata;
        r_wstrb   <= bus.mem_wstrb;
        r_is_read <= w_req_read;
        r_oor     <= 1'b0;
      end
      if (w_accept_oor) begin
        r_oor <= 1'b1;
      end
      // SRAM read data lags the issuing lane by one cycle.
      if (r_state == ACCESS && r_is_read && r_lane != 2'd0) begin
        r_rdata[{w_prev_lane, 3'b000} +: 8] <= sram_dout;
      end
      if (r_state == DRAIN) begin
        if (r_oor)          r_rdata         <= '0;
        else if (r_is_read) r_rdata[31:24]  <= sram_dout;
      end
    end
  end

  assign bus.mem_ready = (r_state == RESP);
  assign bus.mem_rdata = r_rdata;
  assign sram_csb      = r_csb;
  assign sram_web      = r_web;
  assign sram_addr     = r_addr;
  assign sram_din      = r_din;

endmodule
